bcd2bin_dabble: RTL and testbench

BCD2BIN_DABBLE -- requirements
Module: bcd2bin_dabble

---
 rtl/bcd2bin_pkg.sv | 17 +
 rtl/bcd2bin_dabble_nibble_sub3.sv | 13 +
 rtl/bcd2bin_dabble.sv | 124 ++++++++++++
 tb/tb_bcd2bin_dabble.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the BCD-to-binary reverse double-dabble converter:
// FSM state encoding, default sizing and the per-nibble correction constant.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_NUM_DIGITS = 3;
    localparam int DEF_BIN_W      = 10;

    // Amount removed from a BCD nibble that reads >= 8 after the right shift
    localparam logic [3:0] SUB3_CORR = 4'd3;

endpackage

// File: rtl/bcd2bin_dabble_nibble_sub3.sv
// Single-digit correction for reverse double dabble: a nibble that reads
// 8 or more right after the shift had a tens carry land in it (worth 8
// instead of 5), so 3 is taken off to restore a valid decimal digit.
module nibble_sub3
    import bcd2bin_pkg::*;
(
    input  logic [3:0] value,
    output logic [3:0] fixed
);

    assign fixed = (value >= 4'd8) ? (value - SUB3_CORR) : value;

endmodule

// File: rtl/bcd2bin_dabble.sv
// Sequential packed-BCD to binary converter using reverse double dabble.
// One shift/correct iteration per clock, BIN_W iterations per conversion.
// Optional build macro BCD2BIN_DIGIT_CHECK_EN: when defined, a start with any
// digit above 9 skips the shift phase and completes next cycle with err=1 and
// bin_out=0. Without it err is constant 0 and digits are not checked.
module bcd2bin_dabble
    import bcd2bin_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BIN_W      = DEF_BIN_W
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t           state;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_next;
    logic [BIN_W-1:0] bin_reg;
    logic [BIN_W-1:0] bin_next;
    logic [CNT_W-1:0] iter;

    // The pair {bcd_reg, bin_reg} moves right as one word: the BCD LSB drops
    // into the binary MSB, so binary bits emerge LSB first from the top.
    assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_next  = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        nibble_sub3 u_sub3 (
            .value (bcd_shift[4*d +: 4]),
            .fixed (bcd_next[4*d +: 4])
        );
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_reg;

    assign err = err_reg;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`else
    assign err = 1'b0;
`endif

    // Control FSM with datapath and registered outputs; results and the done
    // pulse are registered on entry to DONE so they are visible together.
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            iter    <= '0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        err_reg <= has_bad_digit(bcd_in);
                        if (has_bad_digit(bcd_in)) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            bin_out <= '0;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    iter    <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bin_out <= bin_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_dabble.sv
// Self-checking bench for bcd2bin_dabble: directed vectors, back-to-back
// start, clear abort, digit-check behaviour, exhaustive 000..999 sweep and
// random values, all against an arithmetic decimal-weight reference.
module tb_bcd2bin_dabble;

    localparam int ND  = 3;
    localparam int BW  = 10;
    localparam int LAT = BW + 1;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [9:0]  bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [9:0]  last_exp = '0;
    bit          hold_known = 1'b1;

    bcd2bin_dabble #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
        .clk     (clk),
        .clear   (clear),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference: weighted decimal sum of the three digits
    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Issue one start and observe the conversion; lat counts cycles after the
    // start-accept edge until done is seen (-1 if never within the bound).
    task automatic run_conv(input logic [11:0] bcd, input bit noise,
                            output int lat, output logic [9:0] res,
                            output logic e, output bit pulse_ok,
                            output bit hold_ok, output bit busy_ok);
        lat = -1; res = 'x; e = 'x;
        pulse_ok = 1'b0; hold_ok = 1'b1; busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k; res = bin_out; e = err;
                break;
            end
            if (hold_known && bin_out !== last_exp) hold_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                bcd_in = 12'($urandom);
            end
        end
        start = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            pulse_ok = (done === 1'b0) && (busy === 1'b0) && (bin_out === res);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bin_out !== 10'd0) $display("FAIL reset_bin_out: got %0d expected 0", bin_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        clear = 1'b0;
        last_exp = '0; hold_known = 1'b1;
    endtask

    task automatic test_vectors();
        logic [11:0] vec [3];
        int lat; logic [9:0] res; logic e; bit p, h, b;
        vec[0] = 12'h158; vec[1] = 12'h999; vec[2] = 12'h000;
        for (int i = 0; i < 3; i++) begin
            run_conv(vec[i], 1'b0, lat, res, e, p, h, b);
            n_checks++; if (lat !== LAT) $display("FAIL vec_latency %h: got %0d expected %0d", vec[i], lat, LAT); else n_pass++;
            n_checks++; if (res !== 10'(bcd_value(vec[i]))) $display("FAIL vec_value %h: got %0d expected %0d", vec[i], res, bcd_value(vec[i])); else n_pass++;
            n_checks++; if (e !== 1'b0) $display("FAIL vec_err %h: got %b expected 0", vec[i], e); else n_pass++;
            n_checks++; if (!(p && h && b)) $display("FAIL vec_pulse_hold_busy %h: got %b%b%b expected 111", vec[i], p, h, b); else n_pass++;
            last_exp = 10'(bcd_value(vec[i]));
        end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int lat = -1;
        logic [9:0] res = 'x;
        @(negedge clk);
        start = 1'b1; bcd_in = 12'h042;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) begin lat = k; res = bin_out; end
            end
            start = (k == 5);
            if (k == 5) bcd_in = 12'h777;
        end
        start = 1'b0;
        n_checks++; if (n_done !== 1) $display("FAIL b2b_done_count: got %0d expected 1", n_done); else n_pass++;
        n_checks++; if (lat !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_checks++; if (res !== 10'd42) $display("FAIL b2b_value: got %0d expected 42", res); else n_pass++;
        n_checks++; if (bin_out !== 10'd42) $display("FAIL b2b_hold: got %0d expected 42", bin_out); else n_pass++;
        last_exp = 10'd42;
    endtask

    task automatic test_clear_abort();
        int n_done = 0;
        bit busy_seen = 1'b0;
        int lat; logic [9:0] res; logic e; bit p, h, b;
        @(negedge clk);
        start = 1'b1; bcd_in = 12'h158;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (bin_out !== 10'd0) $display("FAIL abort_bin_out: got %0d expected 0", bin_out); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_checks++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d expected 0", n_done); else n_pass++;
        last_exp = '0;
        run_conv(12'h255, 1'b0, lat, res, e, p, h, b);
        n_checks++; if (res !== 10'd255) $display("FAIL abort_restart_value: got %0d expected 255", res); else n_pass++;
        n_checks++; if (lat !== LAT) $display("FAIL abort_restart_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_checks++; if (!(p && h && b)) $display("FAIL abort_restart_pulse_hold_busy: got %b%b%b expected 111", p, h, b); else n_pass++;
        last_exp = 10'd255;
        // clear and start together: start must be dropped
        @(negedge clk);
        clear = 1'b1; start = 1'b1; bcd_in = 12'h321;
        @(posedge clk);
        #1;
        clear = 1'b0; start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        n_checks++; if (n_done !== 0 || busy_seen) $display("FAIL clear_start_dropped: got done=%0d busy_seen=%b expected 0 0", n_done, busy_seen); else n_pass++;
        n_checks++; if (bin_out !== 10'd0) $display("FAIL clear_start_bin_out: got %0d expected 0", bin_out); else n_pass++;
        last_exp = '0;
    endtask

    task automatic test_digit_check();
        int lat; logic [9:0] res; logic e; bit p, h, b;
        run_conv(12'h1A3, 1'b0, lat, res, e, p, h, b);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        n_checks++; if (lat !== 1) $display("FAIL bad_digit_latency: got %0d expected 1", lat); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL bad_digit_err: got %b expected 1", e); else n_pass++;
        n_checks++; if (res !== 10'd0) $display("FAIL bad_digit_value: got %0d expected 0", res); else n_pass++;
        n_checks++; if (!p) $display("FAIL bad_digit_pulse: got %b expected 1", p); else n_pass++;
        last_exp = '0;
`else
        n_checks++; if (lat !== LAT) $display("FAIL bad_digit_latency: got %0d expected %0d", lat, LAT); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL bad_digit_err: got %b expected 0", e); else n_pass++;
        hold_known = 1'b0;
`endif
        run_conv(12'h007, 1'b0, lat, res, e, p, h, b);
        n_checks++; if (e !== 1'b0 || err !== 1'b0) $display("FAIL err_cleared: got %b/%b expected 0/0", e, err); else n_pass++;
        n_checks++; if (res !== 10'd7) $display("FAIL after_bad_value: got %0d expected 7", res); else n_pass++;
        hold_known = 1'b1;
        last_exp = 10'd7;
    endtask

    task automatic test_exhaustive();
        int lat; logic [9:0] res; logic e; bit p, h, b;
        for (int v = 0; v <= 999; v++) begin
            run_conv(to_bcd(v), 1'b1, lat, res, e, p, h, b);
            n_checks++; if (res !== 10'(v)) $display("FAIL exh_value %0d: got %0d expected %0d", v, res, v); else n_pass++;
            n_checks++; if (lat !== LAT) $display("FAIL exh_latency %0d: got %0d expected %0d", v, lat, LAT); else n_pass++;
            n_checks++; if (!(p && b)) $display("FAIL exh_pulse_busy %0d: got %b%b expected 11", v, p, b); else n_pass++;
            n_checks++; if (!h || e !== 1'b0) $display("FAIL exh_hold_err %0d: got hold=%b err=%b expected 1 0", v, h, e); else n_pass++;
            last_exp = 10'(v);
        end
    endtask

    task automatic test_random();
        int lat; logic [9:0] res; logic e; bit p, h, b;
        int v;
        for (int i = 0; i < 50; i++) begin
            v = int'($urandom_range(0, 999));
            run_conv(to_bcd(v), 1'b1, lat, res, e, p, h, b);
            n_checks++; if (res !== 10'(v) || lat !== LAT) $display("FAIL rnd %0d: got value %0d latency %0d expected %0d %0d", v, res, lat, v, LAT); else n_pass++;
            n_checks++; if (!(p && h && b) || e !== 1'b0) $display("FAIL rnd_ctrl %0d: got %b%b%b err=%b expected 111 0", v, p, h, b, e); else n_pass++;
            last_exp = 10'(v);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_clear_abort();
        test_digit_check();
        test_exhaustive();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
